// File: rtl/coax_rx_frame_ctrl.sv
// coax_rx_frame_ctrl
//   Frame-level controller for the coax receive path. It consumes decoded
//   bit strobes from the bit timer, hunts for the start sequence (a run of
//   ones closed by a zero), then assembles words of the form
//   sync(1) + 10 data bits (MSB first) + parity, until a zero sync bit ends
//   the frame. The controller owns the bit timer reset: after a frame end or
//   any error it holds bit_timer_reset for TIMER_RESET_CYCLES clocks so the
//   timer relocks before the next frame.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | receive not allowed or timer not locked; strobes ignored
//   HUNT    | counting consecutive ones of the start sequence
//   SYNC    | expecting a word sync bit (1 = word follows, 0 = frame end)
//   DATA    | shifting in the 10 data bits
//   PARITY  | expecting the parity bit; publishes the word on its strobe
//   RESYNC  | holding bit_timer_reset, then back to IDLE
//
// Ports
//   clk              receive clock
//   reset_n          asynchronous active-low reset
//   enable           1 = receive allowed
//   synchronized     bit timer locked to the line
//   bit_strobe       one-clock pulse, bit_value valid
//   bit_value        decoded bit
//   bit_timer_reset  active-high reset to the bit timer
//   active           high while inside a frame
//   data             last received word
//   data_strobe      one-clock pulse, data valid
//   parity_error     qualified by data_strobe, word failed even parity
//   frame_end        one-clock pulse, clean end of frame
//   error            one-clock pulse, frame aborted
//   error_code       cause of the last error: 1 sync lost, 2 timeout,
//                    3 bad start, 4 disabled mid-frame

module coax_rx_frame_ctrl #(
  parameter int START_ONES         = 5,
  parameter int TIMEOUT            = 64,
  parameter int TIMER_RESET_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       synchronized,
  input  logic       bit_strobe,
  input  logic       bit_value,
  output logic       bit_timer_reset,
  output logic       active,
  output logic [9:0] data,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       frame_end,
  output logic       error,
  output logic [2:0] error_code
);

  localparam int OW = $clog2(START_ONES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(TIMER_RESET_CYCLES + 1);

  localparam logic [OW-1:0] ONES_MAX = OW'(START_ONES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(TIMER_RESET_CYCLES - 1);

  localparam logic [2:0] ERR_SYNC    = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_START   = 3'd3;
  localparam logic [2:0] ERR_DISABLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_RESYNC
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          word_seen_q, word_seen_d;
  logic [9:0]    data_q, data_d;
  logic          data_strobe_q, data_strobe_d;
  logic          parity_error_q, parity_error_d;
  logic          frame_end_q, frame_end_d;
  logic          error_q, error_d;
  logic [2:0]    error_code_q, error_code_d;
  logic [2:0]    abort_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ones_q         <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      tmo_q          <= '0;
      rst_cnt_q      <= '0;
      word_seen_q    <= 1'b0;
      data_q         <= '0;
      data_strobe_q  <= 1'b0;
      parity_error_q <= 1'b0;
      frame_end_q    <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= '0;
    end else begin
      state_q        <= state_d;
      ones_q         <= ones_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      tmo_q          <= tmo_d;
      rst_cnt_q      <= rst_cnt_d;
      word_seen_q    <= word_seen_d;
      data_q         <= data_d;
      data_strobe_q  <= data_strobe_d;
      parity_error_q <= parity_error_d;
      frame_end_q    <= frame_end_d;
      error_q        <= error_d;
      error_code_q   <= error_code_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ones_d         = ones_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    tmo_d          = tmo_q;
    rst_cnt_d      = rst_cnt_q;
    word_seen_d    = word_seen_q;
    data_d         = data_q;
    data_strobe_d  = 1'b0;
    parity_error_d = 1'b0;
    frame_end_d    = 1'b0;
    error_d        = 1'b0;
    error_code_d   = error_code_q;
    abort_code     = '0;

    unique case (state_q)
      S_IDLE: begin
        ones_d = '0;
        if (enable && synchronized) state_d = S_HUNT;
      end

      S_HUNT: begin
        // Leaving HUNT is silent: no frame has started yet.
        if (!enable || !synchronized) begin
          state_d = S_IDLE;
          ones_d  = '0;
        end else if (bit_strobe) begin
          if (bit_value) begin
            if (ones_q != ONES_MAX) ones_d = ones_q + OW'(1);
          end else if (ones_q == ONES_MAX) begin
            state_d     = S_SYNC;
            ones_d      = '0;
            word_seen_d = 1'b0;
            tmo_d       = TMO_LOAD;
          end else begin
            ones_d = '0;
          end
        end
      end

      S_SYNC, S_DATA, S_PARITY: begin
        // Abort causes in priority order; a strobe is only taken when
        // none of them fires. tmo_q == 0 means TIMEOUT clocks have passed
        // since the last strobe.
        if (!synchronized) begin
          abort_code = ERR_SYNC;
        end else if (!enable) begin
          abort_code = ERR_DISABLE;
        end else if (tmo_q == '0) begin
          abort_code = ERR_TIMEOUT;
        end else if (bit_strobe) begin
          tmo_d = TMO_LOAD;
          if (state_q == S_SYNC) begin
            if (bit_value) begin
              shift_d   = '0;
              bit_cnt_d = 4'd9;
              state_d   = S_DATA;
            end else if (word_seen_q) begin
              frame_end_d = 1'b1;
              rst_cnt_d   = RST_LOAD;
              state_d     = S_RESYNC;
            end else begin
              abort_code = ERR_START;
            end
          end else if (state_q == S_DATA) begin
            shift_d = {shift_q[8:0], bit_value};
            if (bit_cnt_q == 4'd0) state_d = S_PARITY;
            else                   bit_cnt_d = bit_cnt_q - 4'd1;
          end else begin
            data_d         = shift_q;
            data_strobe_d  = 1'b1;
            parity_error_d = ^{shift_q, bit_value};
            word_seen_d    = 1'b1;
            state_d        = S_SYNC;
          end
        end else begin
          tmo_d = tmo_q - TW'(1);
        end

        if (abort_code != '0) begin
          error_d      = 1'b1;
          error_code_d = abort_code;
          rst_cnt_d    = RST_LOAD;
          state_d      = S_RESYNC;
        end
      end

      S_RESYNC: begin
        if (rst_cnt_q == '0) state_d = S_IDLE;
        else                 rst_cnt_d = rst_cnt_q - RW'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The timer is also held in reset while the controller itself is in reset.
  assign bit_timer_reset = !reset_n || (state_q == S_RESYNC);
  assign active          = (state_q == S_SYNC) || (state_q == S_DATA) ||
                           (state_q == S_PARITY);
  assign data            = data_q;
  assign data_strobe     = data_strobe_q;
  assign parity_error    = parity_error_q;
  assign frame_end       = frame_end_q;
  assign error           = error_q;
  assign error_code      = error_code_q;

endmodule
